car_pass_emulator: RTL and testbench
====================================

Name: car_pass_emulator

Overview:
- Generates the two-sensor waveform (a, b) that one car produces when it crosses the parking-lot gate.
- It is the encoder counterpart of the sensor-decoding FSM. Given an enter or exit command, it drives the ordered a/b beam-break sequence that the FSM decodes back into S/R pulses.
- Used as a bench stimulus source and as an on-board demo mode. Its outputs are muxed in place of the raw gate sensors, so the debounce, FSM and counter chain is exercised without a physical gate.
- Also tracks the car count the downstream counter is expected to show.

Parameters:
- PHASE_TICKS, 50, clk cycles each sensor phase is held. Must be >=1. 50 at 1 kHz = 50 ms, longer than the debounce window.
- GAP_TICKS, 50, clk cycles a=b=0 is held after each sequence, before the next may start. Must be >=1.
- CNT_W, 4, width of exp_count. Matches the 4-LED display.

Ports:
- clk  in  1  system clock (1 kHz divided clock in the top level).
- rst_n  in  1  asynchronous active-low reset.
- enter_req  in  1  single-cycle request: emulate a car entering.
- exit_req  in  1  single-cycle request: emulate a car leaving.
- a  out  1  emulated sensor A, 1 = beam blocked.
- b  out  1  emulated sensor B, 1 = beam blocked.
- busy  out  1  a sequence is in progress (PH1..GAP).
- done  out  1  one-cycle pulse when a sequence completes.
- overflow  out  1  one-cycle pulse when a request is dropped.
- exp_count  out  CNT_W  expected occupancy after all completed sequences.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; a=b=busy=done=overflow=0; exp_count=0.
  - Pending slot is cleared; tick counter=0.
  - Takes effect mid-sequence too, with no completion of the sequence.
- All outputs are registered.
- States: IDLE, PH1, PH2, PH3, GAP. Direction register dir (0=enter, 1=exit) is latched when a sequence starts.
- Sensor levels:
  - enter: PH1 a=1 b=0; PH2 a=1 b=1; PH3 a=0 b=1.
  - exit: PH1 a=0 b=1; PH2 a=1 b=1; PH3 a=1 b=0.
  - IDLE and GAP: a=b=0.
- Start timing: a request sampled high at edge k while in IDLE with no pending request gives PH1 outputs from edge k+1. Latency is one cycle.
- Phase durations: PH1, PH2 and PH3 each last exactly PHASE_TICKS cycles. GAP lasts exactly GAP_TICKS cycles.
- Sequence length: 3*PHASE_TICKS+GAP_TICKS cycles.
- busy: 1 in every cycle the state is PH1..GAP.
- done: high for the single cycle after the last GAP cycle.
- exp_count update, in the same cycle as done:
  - enter: +1, saturating at 2^CNT_W-1.
  - exit: -1, saturating at 0.
  - Saturation affects exp_count only. The waveform is still generated.
- Pending slot (one deep):
  - A request arriving while busy is stored in the slot if the slot is empty.
  - If the slot is full, the request is dropped and overflow pulses.
- Leaving GAP:
  - If a request is pending, go directly to PH1 with the pending direction; done and the new PH1 share that cycle. Clear the slot.
  - Otherwise go to IDLE.
- Requests sampled in the final GAP cycle are treated as pending requests.
- enter_req and exit_req in the same cycle:
  - In IDLE: enter starts and exit goes to the pending slot.
  - While busy with the slot empty: enter goes to the slot and exit is dropped, with an overflow pulse.
- Holding a request high for several cycles counts as one request per cycle. Callers pulse for one cycle.
- Tick counter width: $clog2 of max(PHASE_TICKS, GAP_TICKS)+1. It reloads at every state change.

Test Plan (PHASE_TICKS=3, GAP_TICKS=2):
- Enter pulse at cycle 0:
  - (a,b)=(1,0) cycles 1-3, (1,1) 4-6, (0,1) 7-9, (0,0) 10-11.
  - done=1 at cycle 12; exp_count 0->1 at 12; busy=1 cycles 1-11.
- Exit pulse after exp_count=1:
  - (0,1), (1,1), (1,0) for 3 cycles each, then gap.
  - exp_count 1->0 at done.
  - Second exit at count 0: exp_count stays 0, waveform still produced.
- Enter pulse at cycle 0, exit pulse at cycle 5, enter pulse at cycle 6:
  - exit is pending and starts (0,1) at cycle 12, same cycle as done.
  - enter at 6 is dropped; overflow=1 at cycle 7.
  - Final exp_count=0.
- enter_req and exit_req both high in IDLE: enter sequence first, then exit back-to-back with no idle cycle. exp_count goes 0->1->0.
- rst_n low at cycle 5 of an enter sequence: a=b=busy=0 immediately (asynchronous), no done, exp_count=0. Normal operation resumes after release.
- 16 enter sequences back-to-back: exp_count saturates at 15 and the 16th still drives the full waveform.

Source files
------------

// File: rtl/car_pass_emulator.sv
// Drives the a/b beam-break waveform of one car entering or leaving the gate,
// with a one-deep request queue and the occupancy the downstream counter should show.
module car_pass_emulator #(
   parameter int PHASE_TICKS = 50,
   parameter int GAP_TICKS   = 50,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enter_req,
   input  logic             exit_req,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [CNT_W-1:0] exp_count
);

   localparam int TICK_MAX = (PHASE_TICKS > GAP_TICKS) ? PHASE_TICKS : GAP_TICKS;
   localparam int TW       = $clog2(TICK_MAX + 1);

   typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;

   state_t          state_reg;
   logic            dir_reg;
   logic [TW-1:0]   tick_reg;
   logic            pend_valid_reg;
   logic            pend_dir_reg;

   logic            req_any;
   logic            req_dir;
   logic            slot_valid_next;
   logic            slot_dir_next;
   logic            drop;
   logic            phase_end;

   // Enter wins when both arrive together; the loser queues or is dropped.
   always_comb begin
      req_any         = enter_req | exit_req;
      req_dir         = ~enter_req;
      slot_valid_next = pend_valid_reg;
      slot_dir_next   = pend_dir_reg;
      drop            = 1'b0;
      phase_end       = (tick_reg == '0);
      if (state_reg == IDLE) begin
         if (enter_req && exit_req) begin
            slot_valid_next = 1'b1;
            slot_dir_next   = 1'b1;
         end
      end else if (req_any) begin
         if (!pend_valid_reg) begin
            slot_valid_next = 1'b1;
            slot_dir_next   = req_dir;
            drop            = enter_req & exit_req;
         end else begin
            drop = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         dir_reg        <= 1'b0;
         tick_reg       <= '0;
         pend_valid_reg <= 1'b0;
         pend_dir_reg   <= 1'b0;
         a              <= 1'b0;
         b              <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         overflow       <= 1'b0;
         exp_count      <= '0;
      end else begin
         done           <= 1'b0;
         overflow       <= drop;
         pend_valid_reg <= slot_valid_next;
         pend_dir_reg   <= slot_dir_next;
         tick_reg       <= phase_end ? tick_reg : tick_reg - 1'b1;
         case (state_reg)
            IDLE: begin
               if (req_any) begin
                  state_reg <= PH1;
                  dir_reg   <= req_dir;
                  tick_reg  <= TW'(PHASE_TICKS - 1);
                  {a, b}    <= req_dir ? 2'b01 : 2'b10;
                  busy      <= 1'b1;
               end
            end
            PH1: begin
               if (phase_end) begin
                  state_reg <= PH2;
                  tick_reg  <= TW'(PHASE_TICKS - 1);
                  {a, b}    <= 2'b11;
               end
            end
            PH2: begin
               if (phase_end) begin
                  state_reg <= PH3;
                  tick_reg  <= TW'(PHASE_TICKS - 1);
                  {a, b}    <= dir_reg ? 2'b10 : 2'b01;
               end
            end
            PH3: begin
               if (phase_end) begin
                  state_reg <= GAP;
                  tick_reg  <= TW'(GAP_TICKS - 1);
                  {a, b}    <= 2'b00;
               end
            end
            GAP: begin
               if (phase_end) begin
                  done <= 1'b1;
                  if (!dir_reg) begin
                     if (exp_count != {CNT_W{1'b1}}) exp_count <= exp_count + CNT_W'(1);
                  end else begin
                     if (exp_count != '0) exp_count <= exp_count - CNT_W'(1);
                  end
                  // A queued request (including one arriving this cycle) starts with no idle gap.
                  if (slot_valid_next) begin
                     state_reg      <= PH1;
                     dir_reg        <= slot_dir_next;
                     pend_valid_reg <= 1'b0;
                     tick_reg       <= TW'(PHASE_TICKS - 1);
                     {a, b}         <= slot_dir_next ? 2'b01 : 2'b10;
                  end else begin
                     state_reg <= IDLE;
                     busy      <= 1'b0;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               {a, b}    <= 2'b00;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_car_pass_emulator.sv
// Directed checks of the car-pass waveform generator with PHASE_TICKS=3, GAP_TICKS=2.
module tb_car_pass_emulator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enter_req;
   logic       exit_req;
   logic       a, b, busy, done, overflow;
   logic [3:0] exp_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected {a,b} for sequence cycles 1..11, hand-written from the waveform table.
   int ab_enter [11] = '{2, 2, 2, 3, 3, 3, 1, 1, 1, 0, 0};
   int ab_exit  [11] = '{1, 1, 1, 3, 3, 3, 2, 2, 2, 0, 0};

   car_pass_emulator #(.PHASE_TICKS(3), .GAP_TICKS(2), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enter_req (enter_req),
      .exit_req  (exit_req),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .exp_count (exp_count)
   );

   always #5 clk = ~clk;

   // Field order of the packed words: a, b, busy, done, overflow, 7'b0, exp_count.
   function automatic logic [15:0] pack(input int ab, input bit bsy, input bit dn,
                                        input bit ovf, input int cnt);
      logic [1:0] ab2;
      logic [3:0] c4;
      ab2 = ab[1:0];
      c4  = cnt[3:0];
      return {ab2, bsy, dn, ovf, 7'b0, c4};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] observed();
      return {a, b, busy, done, overflow, 7'b0, exp_count};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered in sequence cycle 1; returns in the done cycle (or one cycle later if idle follows).
   task automatic expect_seq(input string tag, input bit dir, input int cnt_in, input int cnt_out,
                             input bit first_done, input bit next_busy, input int next_ab,
                             input int exit_at, input int enter_at, input int ovf_at);
      int ab;
      for (int c = 1; c <= 11; c++) begin
         ab = dir ? ab_exit[c-1] : ab_enter[c-1];
         check($sformatf("%s c%0d", tag, c), observed(),
               pack(ab, 1'b1, (c == 1) ? first_done : 1'b0, c == ovf_at, cnt_in));
         enter_req = (c == enter_at);
         exit_req  = (c == exit_at);
         step();
      end
      enter_req = 1'b0;
      exit_req  = 1'b0;
      check($sformatf("%s done", tag), observed(),
            pack(next_busy ? next_ab : 0, next_busy, 1'b1, 1'b0, cnt_out));
      $display("seq %s dir=%0d count %0d->%0d", tag, dir, cnt_in, cnt_out);
      if (!next_busy) begin
         step();
         check($sformatf("%s idle", tag), observed(), pack(0, 1'b0, 1'b0, 1'b0, cnt_out));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #12;
      check("reset", observed(), pack(0, 1'b0, 1'b0, 1'b0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      enter_req = 1'b0;
      exit_req  = 1'b0;
      do_reset();

      // Single enter, then two exits (second saturates at 0).
      enter_req = 1'b1; step(); enter_req = 1'b0;
      expect_seq("enter1", 1'b0, 0, 1, 1'b0, 1'b0, 0, -1, -1, -1);
      exit_req = 1'b1; step(); exit_req = 1'b0;
      expect_seq("exit1", 1'b1, 1, 0, 1'b0, 1'b0, 0, -1, -1, -1);
      exit_req = 1'b1; step(); exit_req = 1'b0;
      expect_seq("exit_sat0", 1'b1, 0, 0, 1'b0, 1'b0, 0, -1, -1, -1);

      // Enter, exit queued at cycle 5, enter at cycle 6 dropped.
      enter_req = 1'b1; step(); enter_req = 1'b0;
      expect_seq("queue_enter", 1'b0, 0, 1, 1'b0, 1'b1, 1, 5, 6, 7);
      expect_seq("queue_exit", 1'b1, 1, 0, 1'b1, 1'b0, 0, -1, -1, -1);

      // Both requests together in IDLE.
      enter_req = 1'b1; exit_req = 1'b1; step(); enter_req = 1'b0; exit_req = 1'b0;
      expect_seq("both_enter", 1'b0, 0, 1, 1'b0, 1'b1, 1, -1, -1, -1);
      expect_seq("both_exit", 1'b1, 1, 0, 1'b1, 1'b0, 0, -1, -1, -1);

      // Asynchronous reset in cycle 5 of an enter sequence.
      enter_req = 1'b1; step(); enter_req = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("pre_reset c5", observed(), pack(3, 1'b1, 1'b0, 1'b0, 0));
      #2 rst_n = 1'b0;
      #1 check("async_reset", observed(), pack(0, 1'b0, 1'b0, 1'b0, 0));
      step();
      check("reset_hold", observed(), pack(0, 1'b0, 1'b0, 1'b0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         check($sformatf("post_reset %0d", i), observed(), pack(0, 1'b0, 1'b0, 1'b0, 0));
      end
      enter_req = 1'b1; step(); enter_req = 1'b0;
      expect_seq("resume", 1'b0, 0, 1, 1'b0, 1'b0, 0, -1, -1, -1);

      // Sixteen back-to-back enters from zero; count saturates at 15.
      do_reset();
      enter_req = 1'b1; step(); enter_req = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         expect_seq($sformatf("sat%0d", k), 1'b0, (k - 1 > 15) ? 15 : k - 1, (k > 15) ? 15 : k,
                    k > 1, k < 16, 2, -1, (k < 16) ? 5 : -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
